// File: rtl/addr_up_seq_pkg.sv
// Shared definitions for the up-counting address sequencer: default address
// width, FSM state encodings and the full-adder cell used by the incrementers.
package addr_up_seq_pkg;

  localparam int ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One full-adder cell, returned as {carry, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic cin);
    full_add = {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

endpackage

// File: rtl/addr_up_seq_if.sv
// Control and address-stream bundle of the sequencer. The master side is the
// sequencer itself; the slave side is the controller/consumer driving it.
interface addr_up_seq_if
  import addr_up_seq_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] base;
  logic [WIDTH:0]   len;
  logic [WIDTH-1:0] addr;
  logic             addr_valid;
  logic             addr_ready;
  logic             busy;
  logic             done;
  logic             wrapped;

  modport master (
    input  start, abort, base, len, addr_ready,
    output addr, addr_valid, busy, done, wrapped
  );

  modport slave (
    output start, abort, base, len, addr_ready,
    input  addr, addr_valid, busy, done, wrapped
  );

endinterface

// File: rtl/addr_up_seq_inc_nb.sv
// N-bit ripple incrementer (inc_nb): a chain of full-adder cells with the
// second operand tied low and carry-in forced to 1, so y = a + 1 mod 2^N.
// carry_out is high exactly when a was all-ones.
module addr_up_seq_inc_nb
  import addr_up_seq_pkg::*;
#(
  parameter int N = ADDR_W_DEF
) (
  input  logic [N-1:0] a,
  output logic [N-1:0] y,
  output logic         carry_out
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign {carry[i+1], y[i]} = full_add(a[i], 1'b0, carry[i]);
  end

  assign carry_out = carry[N];

endmodule

// File: rtl/addr_up_seq.sv
// Up-counting address sequencer for the operand load path. On an accepted
// start it emits len consecutive addresses from base, one per valid/ready
// handshake, wrapping modulo 2^WIDTH, then pulses done for one cycle.
module addr_up_seq
  import addr_up_seq_pkg::*;
#(
  parameter int WIDTH = ADDR_W_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  addr_up_seq_if.master bus
);

  state_t state, next_state;

  logic [WIDTH-1:0] addr_q, addr_inc;
  logic             addr_co;
  logic [WIDTH:0]   idx_q, idx_inc, len_q;
  logic             idx_co;
  logic             wrapped_q;

  logic valid_q, busy_q, done_q;
  logic valid_d, busy_d, done_d;

  logic hs;
  logic last;

  addr_up_seq_inc_nb #(.N(WIDTH)) u_addr_inc (
    .a         (addr_q),
    .y         (addr_inc),
    .carry_out (addr_co)
  );

  addr_up_seq_inc_nb #(.N(WIDTH+1)) u_idx_inc (
    .a         (idx_q),
    .y         (idx_inc),
    .carry_out (idx_co)
  );

  assign hs = valid_q & bus.addr_ready;

  // idx stays below len, so idx+1 never carries out; folding the carry into
  // the compare keeps the full WIDTH+2-bit result accounted for.
  assign last = ~idx_co & (idx_inc == len_q);

  // State register plus the registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= next_state;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic; abort wins over a same-cycle handshake.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          next_state = (bus.len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (bus.abort) begin
          next_state = IDLE;
        end else if (hs && last) begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Output decode from the next state so every output leaves a flop.
  always_comb begin
    valid_d = (next_state == RUN);
    busy_d  = (next_state == RUN);
    done_d  = (next_state == DONE);
  end

  // Address, index, latched length and sticky wrap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      wrapped_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            wrapped_q <= 1'b0;
            len_q     <= bus.len;
            if (bus.len != '0) begin
              addr_q <= bus.base;
              idx_q  <= '0;
            end
          end
        end
        RUN: begin
          if (!bus.abort && hs && !last) begin
            addr_q <= addr_inc;
            idx_q  <= idx_inc;
            if (addr_co) begin
              wrapped_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.addr       = addr_q;
  assign bus.addr_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.wrapped    = wrapped_q;

endmodule

// File: tb/tb_addr_up_seq.sv
// Bench for addr_up_seq: directed scenarios plus randomized runs, each
// checked against a plain-arithmetic reference of the address stream.
module tb_addr_up_seq;

  logic clk;
  logic rst_n;

  addr_up_seq_if #(.WIDTH(5)) bus ();

  addr_up_seq #(.WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Trace of one run, filled by run_trace.
  logic [4:0] tr_hs_addr[$];
  logic       tr_hs_wrap[$];
  int         tr_hs_cyc[$];
  logic [4:0] tr_valid_addr[$];
  int         tr_done_cnt;
  int         tr_done_cyc;
  int         tr_first_valid;
  int         tr_busy_cnt;
  int         tr_unstable;
  logic       tr_end_wrap;
  bit         tr_end_idle;
  bit         tr_timeout;
  bit         tr_aborted;

  // Reference model: k-th address of a run from base b, and whether the
  // stream has passed the top of the address space by then.
  function automatic logic [4:0] ref_addr(input logic [4:0] b, input int k);
    return 5'((int'(b) + k) % 32);
  endfunction

  function automatic logic ref_wrap(input logic [4:0] b, input int k);
    return ((int'(b) + k) >= 32);
  endfunction

  task automatic run_trace(input logic [4:0] b, input logic [5:0] l, input int pct,
                           input int abort_at, input int stall_at, input int stall_cycles,
                           input bit noise);
    int hs, stall_left, tail;
    bit fin, was_hs, prev_valid;
    logic [4:0] prev_addr;
    tr_hs_addr.delete(); tr_hs_wrap.delete(); tr_hs_cyc.delete(); tr_valid_addr.delete();
    tr_done_cnt = 0; tr_done_cyc = -1; tr_first_valid = -1; tr_busy_cnt = 0;
    tr_unstable = 0; tr_end_wrap = 1'b0; tr_end_idle = 1'b0; tr_timeout = 1'b1; tr_aborted = 1'b0;
    hs = 0; stall_left = stall_cycles; tail = 0; fin = 1'b0; was_hs = 1'b0;
    prev_valid = 1'b0; prev_addr = '0;
    @(posedge clk); #1;
    bus.base = b; bus.len = l; bus.start = 1'b1; bus.abort = 1'b0; bus.addr_ready = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.addr_ready = (int'($urandom_range(0, 99)) < pct);
      if (hs == stall_at && stall_left > 0 && bus.addr_valid) begin
        bus.addr_ready = 1'b0;
        stall_left--;
      end
      if (noise && bus.busy) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.base  = 5'($urandom_range(0, 31));
        bus.len   = 6'($urandom_range(0, 63));
      end
      if (!tr_aborted && abort_at >= 0 && hs == abort_at && bus.busy) begin
        bus.abort = 1'b1;
        bus.addr_ready = 1'b1;
        tr_aborted = 1'b1;
      end
      @(negedge clk);
      if (bus.addr_valid) begin
        tr_valid_addr.push_back(bus.addr);
        if (tr_first_valid < 0) tr_first_valid = c;
        if (prev_valid && !was_hs && bus.addr !== prev_addr) tr_unstable++;
      end
      if (bus.busy) tr_busy_cnt++;
      if (bus.done) begin
        tr_done_cnt++;
        tr_done_cyc = c;
      end
      was_hs = bus.addr_valid && bus.addr_ready && !bus.abort;
      if (was_hs) begin
        tr_hs_addr.push_back(bus.addr);
        tr_hs_wrap.push_back(bus.wrapped);
        tr_hs_cyc.push_back(c);
        hs++;
      end
      prev_valid = bus.addr_valid;
      prev_addr  = bus.addr;
      tr_end_wrap = bus.wrapped;
      tr_end_idle = !bus.addr_valid && !bus.busy && !bus.done;
      if (fin) begin
        tail++;
        if (tail == 2) begin
          tr_timeout = 1'b0;
          break;
        end
      end
      if (bus.done || (tr_aborted && !bus.addr_valid)) fin = 1'b1;
    end
    bus.addr_ready = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.base = '0; bus.len = '0; bus.addr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.addr !== 5'd0) begin n_fail++; $display("FAIL reset_addr: got %0d want 0", bus.addr); end
    n_checks++; if (bus.addr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.addr_valid); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
    n_checks++; if (bus.wrapped !== 1'b0) begin n_fail++; $display("FAIL reset_wrapped: got %b want 0", bus.wrapped); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (bus.addr_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_idle: valid=%b busy=%b want 0 0", bus.addr_valid, bus.busy);
    end
  endtask

  task automatic test_basic;
    run_trace(5'd3, 6'd4, 100, -1, -1, 0, 1'b0);
    n_checks++; if (tr_timeout) begin n_fail++; $display("FAIL basic_timeout: run did not finish"); end
    n_checks++; if (tr_hs_addr.size() != 4) begin n_fail++; $display("FAIL basic_count: got %0d want 4", tr_hs_addr.size()); end
    for (int k = 0; k < tr_hs_addr.size() && k < 4; k++) begin
      n_checks++; if (tr_hs_addr[k] !== ref_addr(5'd3, k) || tr_hs_cyc[k] != k) begin
        n_fail++; $display("FAIL basic_addr[%0d]: got %0d at cycle %0d want %0d at cycle %0d", k, tr_hs_addr[k], tr_hs_cyc[k], ref_addr(5'd3, k), k);
      end
    end
    n_checks++; if (tr_first_valid != 0) begin n_fail++; $display("FAIL basic_latency: first valid cycle %0d want 0", tr_first_valid); end
    n_checks++; if (tr_done_cnt != 1 || tr_done_cyc != 4) begin
      n_fail++; $display("FAIL basic_done: count %0d cycle %0d want 1 at 4", tr_done_cnt, tr_done_cyc);
    end
    n_checks++; if (tr_end_wrap !== 1'b0) begin n_fail++; $display("FAIL basic_wrapped: got %b want 0", tr_end_wrap); end
    n_checks++; if (!tr_end_idle) begin n_fail++; $display("FAIL basic_idle: not idle after done"); end
  endtask

  task automatic test_wrap;
    run_trace(5'd30, 6'd4, 100, -1, -1, 0, 1'b0);
    n_checks++; if (tr_timeout || tr_hs_addr.size() != 4) begin
      n_fail++; $display("FAIL wrap_count: got %0d want 4 (timeout=%0b)", tr_hs_addr.size(), tr_timeout);
    end
    for (int k = 0; k < tr_hs_addr.size() && k < 4; k++) begin
      n_checks++; if (tr_hs_addr[k] !== ref_addr(5'd30, k) || tr_hs_wrap[k] !== ref_wrap(5'd30, k)) begin
        n_fail++; $display("FAIL wrap_addr[%0d]: got addr %0d wrapped %b want %0d %b", k, tr_hs_addr[k], tr_hs_wrap[k], ref_addr(5'd30, k), ref_wrap(5'd30, k));
      end
    end
    n_checks++; if (tr_end_wrap !== 1'b1) begin n_fail++; $display("FAIL wrap_sticky: got %b want 1 after done", tr_end_wrap); end
    run_trace(5'd2, 6'd1, 100, -1, -1, 0, 1'b0);
    n_checks++; if (tr_hs_wrap.size() != 1 || tr_hs_wrap[0] !== 1'b0) begin
      n_fail++; $display("FAIL wrap_clear_on_start: got %b want 0", tr_hs_wrap.size() > 0 ? tr_hs_wrap[0] : 1'bx);
    end
  endtask

  task automatic test_stall;
    int nine;
    run_trace(5'd8, 6'd3, 100, -1, 1, 2, 1'b0);
    nine = 0;
    foreach (tr_valid_addr[i]) if (tr_valid_addr[i] == 5'd9) nine++;
    n_checks++; if (tr_timeout || tr_hs_addr.size() != 3) begin
      n_fail++; $display("FAIL stall_count: got %0d handshakes want 3", tr_hs_addr.size());
    end
    for (int k = 0; k < tr_hs_addr.size() && k < 3; k++) begin
      n_checks++; if (tr_hs_addr[k] !== ref_addr(5'd8, k)) begin
        n_fail++; $display("FAIL stall_addr[%0d]: got %0d want %0d", k, tr_hs_addr[k], ref_addr(5'd8, k));
      end
    end
    n_checks++; if (nine != 3) begin n_fail++; $display("FAIL stall_hold: addr 9 shown %0d cycles want 3", nine); end
    n_checks++; if (tr_unstable != 0) begin n_fail++; $display("FAIL stall_stable: %0d changes while stalled want 0", tr_unstable); end
  endtask

  task automatic test_len_zero;
    run_trace(5'd17, 6'd0, 100, -1, -1, 0, 1'b0);
    n_checks++; if (tr_valid_addr.size() != 0 || tr_busy_cnt != 0) begin
      n_fail++; $display("FAIL len0_valid: valid cycles %0d busy cycles %0d want 0 0", tr_valid_addr.size(), tr_busy_cnt);
    end
    n_checks++; if (tr_timeout || tr_done_cnt != 1 || tr_done_cyc != 0) begin
      n_fail++; $display("FAIL len0_done: count %0d cycle %0d want 1 at 0", tr_done_cnt, tr_done_cyc);
    end
    n_checks++; if (!tr_end_idle) begin n_fail++; $display("FAIL len0_idle: not idle afterwards"); end
  endtask

  task automatic test_full_and_abort;
    int bad;
    run_trace(5'd0, 6'd32, 100, -1, -1, 0, 1'b0);
    bad = 0;
    for (int k = 0; k < tr_hs_addr.size() && k < 32; k++)
      if (tr_hs_addr[k] !== ref_addr(5'd0, k) || tr_hs_cyc[k] != k) bad++;
    n_checks++; if (tr_timeout || tr_hs_addr.size() != 32 || bad != 0) begin
      n_fail++; $display("FAIL full_seq: %0d handshakes, %0d wrong, want 32 and 0", tr_hs_addr.size(), bad);
    end
    n_checks++; if (tr_done_cnt != 1 || tr_end_wrap !== 1'b0) begin
      n_fail++; $display("FAIL full_done: done count %0d wrapped %b want 1 0", tr_done_cnt, tr_end_wrap);
    end
    run_trace(5'd0, 6'd32, 100, 5, -1, 0, 1'b0);
    n_checks++; if (tr_timeout || tr_hs_addr.size() != 5) begin
      n_fail++; $display("FAIL abort_count: got %0d handshakes want 5", tr_hs_addr.size());
    end
    n_checks++; if (tr_valid_addr.size() != 6 || tr_valid_addr[tr_valid_addr.size()-1] !== 5'd5) begin
      n_fail++; $display("FAIL abort_last_valid: %0d valid cycles want 6 ending at addr 5", tr_valid_addr.size());
    end
    n_checks++; if (tr_done_cnt != 0 || !tr_end_idle) begin
      n_fail++; $display("FAIL abort_no_done: done count %0d idle %b want 0 1", tr_done_cnt, tr_end_idle);
    end
  endtask

  task automatic test_reset_mid_run;
    int c;
    @(posedge clk); #1;
    bus.base = 5'd10; bus.len = 6'd20; bus.start = 1'b1; bus.addr_ready = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    c = 0;
    while (!(bus.addr_valid && bus.addr == 5'd12) && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    bus.addr_ready = 1'b0;
    n_checks++; if (!(bus.addr_valid && bus.addr == 5'd12)) begin
      n_fail++; $display("FAIL midrst_reach: addr %0d valid %b want 12 1", bus.addr, bus.addr_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.addr !== 5'd0 || bus.addr_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL midrst_clear: addr %0d valid %b busy %b done %b want 0 0 0 0", bus.addr, bus.addr_valid, bus.busy, bus.done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_trace(5'd5, 6'd2, 100, -1, -1, 0, 1'b0);
    n_checks++; if (tr_timeout || tr_hs_addr.size() != 2 || tr_hs_addr[0] !== 5'd5 || tr_hs_addr[1] !== 5'd6 || tr_done_cnt != 1) begin
      n_fail++; $display("FAIL midrst_restart: %0d handshakes done %0d want 5,6 then done", tr_hs_addr.size(), tr_done_cnt);
    end
  endtask

  task automatic test_random;
    for (int r = 0; r < 40; r++) begin
      logic [4:0] b;
      int l, pct, ab, nexp, bad;
      logic ew;
      b   = 5'($urandom_range(0, 31));
      l   = int'($urandom_range(0, 32));
      pct = int'($urandom_range(30, 100));
      ab  = -1;
      if (l > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, l - 1));
      run_trace(b, 6'(l), pct, ab, -1, 0, 1'b1);
      nexp = (ab >= 0) ? ab : l;
      if (ab >= 0) ew = ref_wrap(b, ab);
      else if (l == 0) ew = 1'b0;
      else ew = ref_wrap(b, l - 1);
      bad = 0;
      for (int k = 0; k < tr_hs_addr.size() && k < nexp; k++)
        if (tr_hs_addr[k] !== ref_addr(b, k) || tr_hs_wrap[k] !== ref_wrap(b, k)) bad++;
      n_checks++; if (tr_timeout || tr_hs_addr.size() != nexp || bad != 0) begin
        n_fail++; $display("FAIL rand_seq[%0d]: base %0d len %0d abort %0d: %0d handshakes %0d wrong want %0d", r, b, l, ab, tr_hs_addr.size(), bad, nexp);
      end
      n_checks++; if (tr_done_cnt != ((ab >= 0) ? 0 : 1) || tr_end_wrap !== ew || !tr_end_idle) begin
        n_fail++; $display("FAIL rand_end[%0d]: done %0d wrapped %b idle %b want %0d %b 1", r, tr_done_cnt, tr_end_wrap, tr_end_idle, (ab >= 0) ? 0 : 1, ew);
      end
      n_checks++; if (tr_unstable != 0 || tr_busy_cnt != tr_valid_addr.size()) begin
        n_fail++; $display("FAIL rand_hold[%0d]: unstable %0d busy %0d valid %0d", r, tr_unstable, tr_busy_cnt, tr_valid_addr.size());
      end
      if (ab < 0 && l > 0 && tr_hs_cyc.size() == l) begin
        n_checks++; if (tr_done_cyc != tr_hs_cyc[l-1] + 1) begin
          n_fail++; $display("FAIL rand_done_cyc[%0d]: got %0d want %0d", r, tr_done_cyc, tr_hs_cyc[l-1] + 1);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_len_zero();
    test_full_and_abort();
    test_reset_mid_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
